program_loader: RTL and testbench

//  Boot-time writer for the shared 8-bit unified RAM: accepts a length-prefixed byte stream

---
 rtl/program_loader.sv | 150 +++++++++++++++
 tb/tb_program_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time loader: writes a length-prefixed byte stream into the unified RAM and holds the CPU
// until the image is complete. Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module program_loader #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic                w_accept;
    logic                w_loading;

    assign w_loading  = (r_state == S_LEN) || (r_state == S_LOAD) || (r_state == S_CHK);
    assign w_accept   = i_in_valid && w_loading;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum <= '0;
        end else if (w_accept && r_state == S_LEN) begin
            r_sum <= '0;
        end else if (w_accept && r_state == S_LOAD) begin
            r_sum <= r_sum + i_in_data;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_accept) begin
                    if (i_in_data != '0) begin
                        w_next = S_LOAD;
                    end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_DONE;
`endif
                    end
                end
            end
            S_LOAD: begin
                if (w_accept && r_cnt == DATA_W'(1)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) w_next = (i_in_data == r_sum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (i_start) w_next = S_LEN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Write strobe is registered: byte accepted on edge k lands in RAM during cycle k+1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
            r_ptr       <= BASE_ADDR;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_LEN: begin
                        r_cnt <= i_in_data;
                        r_ptr <= BASE_ADDR;
                    end
                    S_LOAD: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_ptr;
                        r_mem_wdata <= i_in_data;
                        r_ptr       <= r_ptr + ADDR_W'(1);
                        r_cnt       <= r_cnt - DATA_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Release waits for the final write strobe to retire so the CPU never runs alongside it.
    assign o_done      = (r_state == S_DONE) && !r_mem_we;
    assign o_cpu_hold  = !o_done;
    assign o_busy      = w_loading || r_mem_we;
    assign o_in_ready  = w_loading;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign o_err       = (r_state == S_ERR);
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (base 00 and FE) share one stimulus stream;
// expected RAM writes are queued at acceptance and popped by a monitor on each write strobe.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] in_data;
    logic       rdy0, we0, hold0, busy0, done0, err0;
    logic       rdy1, we1, hold1, busy1, done1, err1;
    logic [7:0] addr0, wd0, addr1, wd1;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(rdy0), .o_mem_addr(addr0), .o_mem_wdata(wd0), .o_mem_we(we0),
        .o_cpu_hold(hold0), .o_busy(busy0), .o_done(done0), .o_err(err0)
    );

    program_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'hFE)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid), .i_in_data(in_data),
        .o_in_ready(rdy1), .o_mem_addr(addr1), .o_mem_wdata(wd1), .o_mem_we(we1),
        .o_cpu_hold(hold1), .o_busy(busy1), .o_done(done1), .o_err(err1)
    );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        q0[$];
    wr_t        q1[$];
    logic [7:0] pl[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, in cycle, address and data.
    always @(negedge clk) begin
        wr_t e;
        if (we0) begin
            chk("hold_during_we0", 32'(hold0), 32'd1);
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we0 actual=%0h:%0h expected=none", addr0, wd0);
            end else begin
                e = q0.pop_front();
                chk("wr_cycle0", 32'(cyc), 32'(e.cyc));
                chk("wr_addr0", 32'(addr0), 32'(e.addr));
                chk("wr_data0", 32'(wd0), 32'(e.data));
            end
        end
        if (we1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we1 actual=%0h:%0h expected=none", addr1, wd1);
            end else begin
                e = q1.pop_front();
                chk("wr_cycle1", 32'(cyc), 32'(e.cyc));
                chk("wr_addr1", 32'(addr1), 32'(e.addr));
                chk("wr_data1", 32'(wd1), 32'(e.data));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // k < 0 marks a non-payload byte (length or checksum).
    task automatic send(input logic [7:0] b, input int k);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!rdy0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready0", 32'(rdy0), 32'd1);
        chk("in_ready1", 32'(rdy1), 32'd1);
        if (k >= 0) begin
            q0.push_back('{cyc + 1, 8'(k), b});
            q1.push_back('{cyc + 1, 8'(8'hFE + 8'(k)), b});
        end
        last_acc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input int n, input int gap, input bit bad);
        logic [7:0] s = 8'h00;
        bit         e;
        int         t = 0;
        int         off;
        e   = CK && bad;
        off = (CK || n == 0) ? 0 : 1;
        do_start();
        send(8'(n), -1);
        for (int k = 0; k < n; k++) begin
            if (gap > 0) step(gap);
            send(pl[k], k);
            s = 8'(s + pl[k]);
        end
        if (CK) begin
            if (gap > 0) step(gap);
            send(bad ? 8'(s + 8'd1) : s, -1);
        end
        @(negedge clk);
        while (!(done0 || err0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("finish_cycle", 32'(cyc), 32'(last_acc + off));
        chk("done0", 32'(done0), 32'(!e));
        chk("err0", 32'(err0), 32'(e));
        chk("hold0", 32'(hold0), 32'(e));
        chk("busy0", 32'(busy0), 32'd0);
        chk("ready_after0", 32'(rdy0), 32'd0);
        chk("done1", 32'(done1), 32'(!e));
        chk("err1", 32'(err1), 32'(e));
        chk("writes_drained0", 32'(q0.size()), 32'd0);
        chk("writes_drained1", 32'(q1.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(we0 | we1), 32'd0);
        chk({tag, "_hold"}, 32'(hold0 & hold1), 32'd1);
        chk({tag, "_busy"}, 32'(busy0 | busy1), 32'd0);
        chk({tag, "_done"}, 32'(done0 | done1), 32'd0);
        chk({tag, "_err"}, 32'(err0 | err1), 32'd0);
        chk({tag, "_ready"}, 32'(rdy0 | rdy1), 32'd0);
        chk({tag, "_addr0"}, 32'(addr0), 32'h00);
        chk({tag, "_addr1"}, 32'(addr1), 32'hFE);
        chk({tag, "_wdata"}, 32'(wd0), 32'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h55;

        // Reset held, then released with no start: everything stays quiet despite in_valid.
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("rst_hold");
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk_reset_outputs("idle");
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        pl = '{8'hA1, 8'hB2, 8'hC3};
        load(3, 0, 1'b0);

        // Restart from DONE with gapped input; base FE instance wraps FE,FF,00.
        pl = '{8'h11, 8'h22, 8'h33};
        load(3, 3, 1'b0);

        pl = '{8'h10, 8'h20};
        load(2, 0, 1'b1);

        // Reset after the second payload byte of a 5-byte image.
        do_start();
        send(8'd5, -1);
        send(8'h01, 0);
        send(8'h02, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        q0.delete();
        q1.delete();
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_rst");
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load(5, 0, 1'b0);

        pl.delete();
        load(0, 0, 1'b0);
        load(0, 0, 1'b1);
        pl = '{8'h05, 8'h06};
        load(2, 1, 1'b0);

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
